// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit.
// Fixed-latency multiply, radix-2 restoring divide on operand magnitudes,
// single-cycle shortcuts for divide-by-zero and signed overflow, and a
// valid/ready result handshake that holds the result until it is consumed.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int TAG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int CNT_W = $clog2(XLEN) + 1;
  // Counter value on the last MUL / DIV cycle before moving to DONE.
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q;      // multiplicand, or dividend/quotient shift register
  logic [XLEN-1:0]   b_q;      // multiplier, or divisor magnitude
  logic [XLEN-1:0]   rem_q;    // partial remainder
  logic              neg_quot_q, neg_rem_q;
  logic [XLEN-1:0]   res_q;
  logic [TAG_W-1:0]  tag_q;

  logic              accept;
  logic              in_signed_div, div_zero, div_ovf, div_fast;
  logic [XLEN-1:0]   fast_res, a_mag, b_mag;
  logic [2:0]        m_op;
  logic [XLEN-1:0]   m_a, m_b, mul_res;
  logic [2*XLEN-1:0] m_ext_a, m_ext_b, m_prod;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_bit;
  logic [XLEN-1:0]   rem_next, quot_next, div_res;

  assign in_ready   = (state == IDLE) && !kill;
  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = res_q;
  assign out_tag    = tag_q;

  // Request decode: divide shortcuts and operand magnitudes for the divider.
  always_comb begin
    in_signed_div = ~in_op[0];
    div_zero      = (in_b == '0);
    div_ovf       = in_signed_div && (in_a == MOST_NEG) && (in_b == '1);
    div_fast      = div_zero || div_ovf;
    if (div_zero) fast_res = in_op[1] ? in_a : '1;
    else          fast_res = in_op[1] ? '0   : in_a;
    a_mag = (in_signed_div && in_a[XLEN-1]) ? -in_a : in_a;
    b_mag = (in_signed_div && in_b[XLEN-1]) ? -in_b : in_b;
  end

  // Shared multiplier: live inputs when idle (single-cycle latency), else latched operands.
  always_comb begin
    m_op    = (state == IDLE) ? in_op : op_q;
    m_a     = (state == IDLE) ? in_a  : a_q;
    m_b     = (state == IDLE) ? in_b  : b_q;
    m_ext_a = {{XLEN{(m_op[1:0] != 2'b11) && m_a[XLEN-1]}}, m_a};
    m_ext_b = {{XLEN{!m_op[1] && m_b[XLEN-1]}}, m_b};
    m_prod  = m_ext_a * m_ext_b;
    mul_res = (m_op[1:0] == 2'b00) ? m_prod[XLEN-1:0] : m_prod[2*XLEN-1:XLEN];
  end

  // One restoring-divide step plus the sign fix applied to its outcome.
  always_comb begin
    div_shift = {rem_q, a_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_bit   = ~div_diff[XLEN];
    rem_next  = div_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    quot_next = {a_q[XLEN-2:0], div_bit};
    if (op_q[1]) div_res = neg_rem_q  ? -rem_next  : rem_next;
    else         div_res = neg_quot_q ? -quot_next : quot_next;
  end

  // Next-state logic; kill overrides every other transition.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    state_d = state;
    unique case (state)
      IDLE: if (accept) begin
        if (!in_op[2]) state_d = (MUL_CYCLES == 1) ? DONE : MUL;
        else           state_d = div_fast ? DONE : DIV;
      end
      MUL:  if (cnt == MUL_LAST) state_d = DONE;
      DIV:  if (cnt == DIV_LAST) state_d = DONE;
      DONE: if (out_ready)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // State register plus the reset-visible result, tag and counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      res_q <= '0;
      tag_q <= '0;
    end else begin
      state <= state_d;
      if (kill) begin
        cnt <= '0;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            cnt   <= '0;
            tag_q <= in_tag;
            if (!in_op[2]) res_q <= mul_res;
            else           res_q <= fast_res;
          end
          MUL: begin
            cnt   <= cnt + CNT_W'(1);
            res_q <= mul_res;
          end
          DIV: begin
            cnt   <= cnt + CNT_W'(1);
            res_q <= div_res;
          end
          default: ;
        endcase
      end
    end
  end

  // Operand and divider datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: these are not reset; every path that reads them loads them on accept first.
    unique case (state)
      IDLE: if (accept) begin
        op_q <= in_op;
        if (!in_op[2]) begin
          a_q <= in_a;
          b_q <= in_b;
        end else begin
          a_q        <= a_mag;
          b_q        <= b_mag;
          rem_q      <= '0;
          neg_quot_q <= in_signed_div && (in_a[XLEN-1] ^ in_b[XLEN-1]);
          neg_rem_q  <= in_signed_div && in_a[XLEN-1];
        end
      end
      DIV: begin
        a_q   <= quot_next;
        rem_q <= rem_next;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, hold/kill/reset
// scenarios and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int MC   = 2;
  localparam int TW   = 5;

  logic            clk, rst_n, in_valid, in_ready, kill, out_valid, out_ready, busy;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a, in_b, out_result;
  logic [TW-1:0]   in_tag, out_tag;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(XLEN), .MUL_CYCLES(MC), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // RISC-V M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, pu;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = 64'(a);
    ub  = 64'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; p = pu; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return $signed(a) / $signed(b);
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'd0; else return $signed(a) % $signed(b);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MC;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Issue one request, measure latency, check result/tag, hold for `hold` cycles, then consume.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TW-1:0] tag, input int hold);
    int          n;
    logic [31:0] exp_r;
    exp_r = ref_result(op, a, b);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b0;
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = ~tag; in_op = 3'($urandom);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(ref_latency(op, a, b)));
    check("result", 64'(out_result), 64'(exp_r));
    check("tag", 64'(out_tag), 64'(tag));
    check("done_not_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_result", 64'(out_result), 64'(exp_r));
      check("hold_tag", 64'(out_tag), 64'(tag));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_dropped", 64'(out_valid), 64'd0);
    check("ready_after", 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    kill = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed corner cases.
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd2, 0);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3, 0);
    run_op(3'd4, -32'sd7, 32'd2, 5'd4, 0);
    run_op(3'd6, -32'sd7, 32'd2, 5'd5, 0);
    run_op(3'd5, 32'd100, 32'd0, 5'd6, 0);
    run_op(3'd7, 32'd100, 32'd0, 5'd8, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    run_op(3'd4, 32'd100, 32'd0, 5'd11, 5);

    // Kill in the middle of a divide, with a competing request presented.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'd1000; in_b = 32'd7; in_tag = 5'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_a = 32'd3; in_b = 32'd3;
    check("kill_blocks_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    kill = 1'b0; in_valid = 1'b0;
    check("kill_busy", 64'(busy), 64'd0);
    check("kill_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1;
    end
    check("kill_no_result", 64'(seen), 64'd0);

    // Reset during a multiply.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd5; in_b = 32'd6; in_tag = 5'd13;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mul_started", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    check("rstmid_result", 64'(out_result), 64'd0);
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("rstmid_no_result", 64'(seen), 64'd0);

    // Randomized operations.
    for (int k = 0; k < 200; k++) begin
      run_op(3'($urandom), pick_operand(), pick_operand(), TW'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
